// File: rtl/port_ctrl_pkg.sv
// Shared types and sizing helpers for the lock-port controller array.
package port_ctrl_pkg;

    typedef enum logic [1:0] {
        CLOSED  = 2'b00,
        OPENING = 2'b01,
        OPEN    = 2'b10,
        CLOSING = 2'b11
    } port_state_t;

    // One spare bit above the largest count keeps the terminal compare wrap-free.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus stability counter; pulses toggle on each accepted level change.
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw,
    output logic level,
    output logic toggle
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] cnt;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            toggle <= 1'b0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            toggle <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                // This edge is the DEBOUNCE_CYCLES-th consecutive mismatch.
                level  <= sync2;
                cnt    <= '0;
                toggle <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_ctrl_array.sv
// Per-channel port FSMs with travel timers and a one-port-away-from-closed interlock.
module port_ctrl_array
    import port_ctrl_pkg::*;
#(
    parameter int NUM_PORTS       = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TRAVEL_CYCLES   = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [NUM_PORTS-1:0] SwitchFlip,
    output logic [NUM_PORTS-1:0] OpenClose,
    output logic [NUM_PORTS-1:0] Moving,
    output logic [NUM_PORTS-1:0] Reject,
    output logic                 Busy
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES, TRAVEL_CYCLES);

    logic        [NUM_PORTS-1:0]         req;
    port_state_t [NUM_PORTS-1:0]         state, state_nxt;
    logic        [NUM_PORTS-1:0][CW-1:0] cnt, cnt_nxt;
    logic        [NUM_PORTS-1:0]         rej_nxt;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_db
        switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .Clock  (Clock),
            .Reset  (Reset),
            .raw    (SwitchFlip[g]),
            .level  (),
            .toggle (req[g])
        );
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= {NUM_PORTS{CLOSED}};
            cnt    <= '0;
            Reject <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            Reject <= rej_nxt;
        end
    end

    always_comb begin
        logic lower_grant;
        logic others_closed;
        state_nxt   = state;
        cnt_nxt     = cnt;
        rej_nxt     = '0;
        lower_grant = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            others_closed = 1'b1;
            for (int j = 0; j < NUM_PORTS; j++)
                if (j != i && state[j] != CLOSED) others_closed = 1'b0;
            case (state[i])
                CLOSED: begin
                    if (req[i]) begin
                        // Lowest requesting index wins; the rest are refused, never queued.
                        if (others_closed && !lower_grant) begin
                            state_nxt[i] = OPENING;
                            cnt_nxt[i]   = '0;
                            lower_grant  = 1'b1;
                        end else begin
                            rej_nxt[i] = 1'b1;
                        end
                    end
                end
                OPENING, CLOSING: begin
                    if (req[i]) rej_nxt[i] = 1'b1;
                    if (cnt[i] == CW'(TRAVEL_CYCLES - 1)) begin
                        state_nxt[i] = (state[i] == OPENING) ? OPEN : CLOSED;
                        cnt_nxt[i]   = '0;
                    end else begin
                        cnt_nxt[i] = cnt[i] + 1'b1;
                    end
                end
                OPEN: begin
                    if (req[i]) begin
                        state_nxt[i] = CLOSING;
                        cnt_nxt[i]   = '0;
                    end
                end
                default: state_nxt[i] = CLOSED;
            endcase
        end
    end

    always_comb begin
        OpenClose = '0;
        Moving    = '0;
        Busy      = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            OpenClose[i] = (state[i] == OPEN);
            Moving[i]    = (state[i] == OPENING) || (state[i] == CLOSING);
            Busy         = Busy | (state[i] != CLOSED);
        end
    end

endmodule

// File: tb/tb_port_ctrl_array.sv
module tb_port_ctrl_array;
  localparam int NP = 2;
  localparam int DB = 4;
  localparam int TR = 8;
  localparam int VW = 3 * NP + 1;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [NP-1:0] SwitchFlip = '0;
  logic [NP-1:0] OpenClose, Moving, Reject;
  logic          Busy;

  port_ctrl_array #(.NUM_PORTS(NP), .DEBOUNCE_CYCLES(DB), .TRAVEL_CYCLES(TR)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .SwitchFlip (SwitchFlip),
    .OpenClose  (OpenClose),
    .Moving     (Moving),
    .Reject     (Reject),
    .Busy       (Busy)
  );

  always #5 Clock = ~Clock;

  logic [VW-1:0] expq[$];
  int vectors = 0;
  int errors  = 0;

  int  ph[NP], nph[NP], tend[NP], run[NP];
  bit  s1[NP], s2[NP], lvl[NP], req[NP], nreq[NP];
  int  cyc = 0;
  bit  started = 0;

  always @(posedge Clock) begin
    logic [NP-1:0] e_oc, e_mv, e_rj;
    bit granted, others_closed;
    e_oc = '0; e_mv = '0; e_rj = '0;
    if (Reset) begin
      started = 1;
      for (int i = 0; i < NP; i++) begin
        ph[i] = 0; tend[i] = 0; run[i] = 0;
        s1[i] = 0; s2[i] = 0; lvl[i] = 0; req[i] = 0;
      end
      expq.push_back('0);
    end else if (started) begin
      granted = 0;
      for (int i = 0; i < NP; i++) nph[i] = ph[i];
      for (int i = 0; i < NP; i++) begin
        if (req[i]) begin
          if (ph[i] == 2) begin
            nph[i] = 3; tend[i] = cyc + TR;
          end else if (ph[i] == 1 || ph[i] == 3) begin
            e_rj[i] = 1'b1;
          end else begin
            others_closed = 1;
            for (int j = 0; j < NP; j++) if (j != i && ph[j] != 0) others_closed = 0;
            if (others_closed && !granted) begin
              granted = 1; nph[i] = 1; tend[i] = cyc + TR;
            end else e_rj[i] = 1'b1;
          end
        end else if ((ph[i] == 1 || ph[i] == 3) && cyc == tend[i]) begin
          nph[i] = (ph[i] == 1) ? 2 : 0;
        end
        if (req[i] && (ph[i] == 1 || ph[i] == 3) && cyc == tend[i])
          nph[i] = (ph[i] == 1) ? 2 : 0;
      end
      for (int i = 0; i < NP; i++) begin
        ph[i] = nph[i];
        nreq[i] = 0;
        if (s2[i] != lvl[i]) begin
          run[i]++;
          if (run[i] == DB) begin lvl[i] = s2[i]; run[i] = 0; nreq[i] = 1; end
        end else run[i] = 0;
        s2[i] = s1[i];
        s1[i] = SwitchFlip[i];
        req[i] = nreq[i];
        e_oc[i] = (ph[i] == 2);
        e_mv[i] = (ph[i] == 1 || ph[i] == 3);
      end
      expq.push_back({e_oc, e_mv, e_rj, (e_oc | e_mv) != '0});
    end
    cyc++;
  end

  always @(negedge Clock) begin
    logic [VW-1:0] exp_v, act_v;
    if (expq.size() > 0) begin
      exp_v = expq.pop_front();
      act_v = {OpenClose, Moving, Reject, Busy};
      vectors++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs @%0t: got oc=%b mv=%b rj=%b busy=%b, want oc=%b mv=%b rj=%b busy=%b",
                 $time, OpenClose, Moving, Reject, Busy,
                 exp_v[VW-1 -: NP], exp_v[2*NP -: NP], exp_v[NP -: NP], exp_v[0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  initial begin
    bit seen;
    step(3);
    Reset = 1'b0;              step(20);
    if ({OpenClose, Moving, Reject, Busy} !== '0) begin
      errors++;
      $display("FAIL reset state @%0t: oc=%b mv=%b rj=%b busy=%b", $time, OpenClose, Moving, Reject, Busy);
    end
    SwitchFlip = 2'b01;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      step(1);
      if (OpenClose[0]) seen = 1;
    end
    if (!seen) begin
      errors++;
      $display("FAIL wait expired @%0t: ch0 never reached OPEN", $time);
    end
    SwitchFlip = 2'b00;        step(25);
    SwitchFlip = 2'b01;        step(3);
    SwitchFlip = 2'b00;        step(15);
    SwitchFlip = 2'b01;        step(25);
    SwitchFlip = 2'b11;        step(15);
    SwitchFlip = 2'b00;        step(30);
    Reset = 1'b1;              step(2);
    Reset = 1'b0;              step(20);
    SwitchFlip = 2'b11;        step(30);
    Reset = 1'b1; SwitchFlip = 2'b00; step(2);
    Reset = 1'b0;              step(20);
    SwitchFlip = 2'b01;        step(9);
    Reset = 1'b1;              step(1);
    Reset = 1'b0;              step(30);
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 49) == 0) begin
        Reset = 1'b1; step(1); Reset = 1'b0;
      end
      SwitchFlip = NP'($urandom);
      step($urandom_range(1, 20));
    end
    step(3);
    if (errors != 0) $display("FAIL: %0d miscompares", errors);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
